// File: rtl/systolic_array_4x4_scheduler.sv
// Sequencer for a 4x4 output-stationary systolic multiplier: buffers A/B operands,
// streams them diagonally skewed into the array, then captures the 16 results.
module systolic_array_4x4_scheduler #(
    parameter int ARRAY_SIZE   = 4,
    parameter int DW_IN        = 8,
    parameter int DW_OUT       = 2*DW_IN + $clog2(ARRAY_SIZE),
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ld_valid,
    output logic                                   ld_ready,
    input  logic                                   ld_sel,
    input  logic [1:0]                             ld_row,
    input  logic [1:0]                             ld_col,
    input  logic [DW_IN-1:0]                       ld_data,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic [ARRAY_SIZE*DW_IN-1:0]            a_feed,
    output logic [ARRAY_SIZE*DW_IN-1:0]            b_feed,
    output logic                                   arr_clr_n,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DW_OUT-1:0] c_in,
    input  logic [1:0]                             rd_row,
    input  logic [1:0]                             rd_col,
    output logic [DW_OUT-1:0]                      rd_data
);
    localparam int N   = ARRAY_SIZE;
    localparam int TW  = $clog2(2*N);
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [TW-1:0]  LAST_T = TW'(2*N-2);
    localparam logic [DCW-1:0] LAST_D = DCW'(DRAIN_CYCLES-1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CLEAR   = 3'd1;
    localparam logic [2:0] FEED    = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] CAPTURE = 3'd4;

    logic [2:0]         state;
    logic [TW-1:0]      feed_cnt;
    logic [TW-1:0]      next_t;
    logic [DCW-1:0]     drain_cnt;
    logic [DW_IN-1:0]   a_buf [N][N];
    logic [DW_IN-1:0]   b_buf [N][N];
    logic [DW_OUT-1:0]  res_buf [N*N];
    logic [N*DW_IN-1:0] a_next;
    logic [N*DW_IN-1:0] b_next;

    assign ld_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == CAPTURE);
    assign arr_clr_n = ~rst & (state != CLEAR);
    assign rd_data   = res_buf[{rd_row, rd_col}];

    // Feeds are registered, so compute the slice for the feed index of the coming cycle.
    assign next_t = (state == CLEAR) ? '0 : feed_cnt + TW'(1);

    always_comb begin
        a_next = '0;
        b_next = '0;
        for (int l = 0; l < N; l++) begin
            for (int k = 0; k < N; k++) begin
                if (next_t == TW'(l + k)) begin
                    a_next[l*DW_IN +: DW_IN] = a_buf[l][k];
                    b_next[l*DW_IN +: DW_IN] = b_buf[k][l];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_buf[i][j] <= '0;
                    b_buf[i][j] <= '0;
                end
            end
        end else if (state == IDLE && ld_valid) begin
            if (ld_sel) begin
                b_buf[ld_row][ld_col] <= ld_data;
            end else begin
                a_buf[ld_row][ld_col] <= ld_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N*N; k++) begin
                res_buf[k] <= '0;
            end
        end else if (state == CAPTURE) begin
            for (int k = 0; k < N*N; k++) begin
                res_buf[k] <= c_in[k*DW_OUT +: DW_OUT];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            feed_cnt  <= '0;
            drain_cnt <= '0;
            a_feed    <= '0;
            b_feed    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    state    <= FEED;
                    feed_cnt <= '0;
                    a_feed   <= a_next;
                    b_feed   <= b_next;
                end
                FEED: begin
                    if (feed_cnt == LAST_T) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        a_feed    <= '0;
                        b_feed    <= '0;
                    end else begin
                        feed_cnt <= next_t;
                        a_feed   <= a_next;
                        b_feed   <= b_next;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_D) begin
                        state <= CAPTURE;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_array_4x4_scheduler.sv
// Bench for the systolic scheduler: a behavioural 4x4 output-stationary array consumes the
// feeds, and captured results are compared against a plain matrix product.
module tb_systolic_array_4x4_scheduler;
    localparam int N = 4;
    localparam int DW_IN = 8;
    localparam int DW_OUT = 18;

    logic clk = 0;
    logic rst = 1;
    logic ld_valid = 0, ld_sel = 0, start = 0;
    logic [1:0] ld_row = 0, ld_col = 0, rd_row = 0, rd_col = 0;
    logic [DW_IN-1:0] ld_data = 0;
    logic ld_ready, busy, done, arr_clr_n;
    logic [N*DW_IN-1:0] a_feed, b_feed;
    logic [N*N*DW_OUT-1:0] c_in;
    logic [DW_OUT-1:0] rd_data;

    int checks = 0;
    int errors = 0;
    int ma [4][4];
    int mb [4][4];

    logic [N*DW_IN-1:0] obs_a [0:19];
    logic [N*DW_IN-1:0] obs_b [0:19];
    logic obs_clr [0:19];
    logic obs_busy [0:19];
    logic obs_done [0:19];
    logic obs_rdy [0:19];

    systolic_array_4x4_scheduler #(
        .ARRAY_SIZE(N), .DW_IN(DW_IN), .DW_OUT(DW_OUT), .DRAIN_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
        .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data), .start(start), .busy(busy),
        .done(done), .a_feed(a_feed), .b_feed(b_feed), .arr_clr_n(arr_clr_n), .c_in(c_in),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural output-stationary array: A moves right, B moves down, each PE accumulates.
    int acc [4][4];
    int ar [4][4];
    int br [4][4];
    int av, bv;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (!arr_clr_n) begin
                    acc[i][j] <= 0;
                    ar[i][j] <= 0;
                    br[i][j] <= 0;
                end else begin
                    if (j == 0) av = int'($signed(a_feed[i*8 +: 8]));
                    else        av = ar[i][j-1];
                    if (i == 0) bv = int'($signed(b_feed[j*8 +: 8]));
                    else        bv = br[i-1][j];
                    acc[i][j] <= acc[i][j] + av * bv;
                    ar[i][j] <= av;
                    br[i][j] <= bv;
                end
            end
        end
    end

    always_comb begin
        c_in = '0;
        for (int k = 0; k < 16; k++) c_in[k*DW_OUT +: DW_OUT] = DW_OUT'(acc[k/4][k%4]);
    end

    function automatic int ref_c(int i, int j);
        int s = 0;
        for (int k = 0; k < 4; k++) s += ma[i][k] * mb[k][j];
        return s;
    endfunction

    function automatic int exp_a(int l, int t);
        int k = t - l;
        if (k >= 0 && k < 4) return ma[l][k];
        return 0;
    endfunction

    function automatic int exp_b(int l, int t);
        int k = t - l;
        if (k >= 0 && k < 4) return mb[k][l];
        return 0;
    endfunction

    function automatic int lane(logic [N*DW_IN-1:0] v, int l);
        return int'($signed(v[l*8 +: 8]));
    endfunction

    task automatic load_all();
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    ld_valid = 1; ld_sel = s[0]; ld_row = 2'(r); ld_col = 2'(c);
                    ld_data = (s == 0) ? 8'(ma[r][c]) : 8'(mb[r][c]);
                end
            end
        end
        @(negedge clk);
        ld_valid = 0;
    endtask

    task automatic randomize_mats();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = int'($urandom_range(0, 255)) - 128;
                mb[r][c] = int'($urandom_range(0, 255)) - 128;
            end
        end
    endtask

    // Starts a run and records outputs for cycles 1..19 (cycle 1 follows the start edge).
    task automatic do_run(input bit inject, input bit same_write);
        @(negedge clk);
        start = 1;
        if (same_write) begin
            ld_valid = 1; ld_sel = 0; ld_row = 0; ld_col = 0; ld_data = 8'd9;
            ma[0][0] = 9;
        end
        @(negedge clk);
        start = 0; ld_valid = 0;
        for (int cyc = 1; cyc < 20; cyc++) begin
            obs_a[cyc] = a_feed; obs_b[cyc] = b_feed; obs_clr[cyc] = arr_clr_n;
            obs_busy[cyc] = busy; obs_done[cyc] = done; obs_rdy[cyc] = ld_ready;
            if (inject && cyc == 4) begin
                ld_valid = 1; start = 1; ld_sel = 1'($urandom);
                ld_row = 2'($urandom); ld_col = 2'($urandom); ld_data = 8'($urandom);
            end else begin
                ld_valid = 0; start = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 0 || done !== 0 || arr_clr_n !== 0 || a_feed !== '0 || b_feed !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b clr_n=%b a=%h b=%h required 0 0 0 0 0",
                     busy, done, arr_clr_n, a_feed, b_feed);
        end
        for (int k = 0; k < 16; k += 5) begin
            rd_row = 2'(k/4); rd_col = 2'(k%4); #1;
            checks++;
            if (rd_data !== '0) begin
                errors++; $display("FAIL reset_rd C[%0d] got %0d required 0", k, rd_data);
            end
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (arr_clr_n !== 1 || ld_ready !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL reset_release clr_n=%b ready=%b busy=%b required 1 1 0", arr_clr_n, ld_ready, busy);
        end
        $display("reset: checked");
    endtask

    task automatic test_identity();
        int bad;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = (r == c) ? 1 : 0;
                mb[r][c] = r*4 + c + 1;
            end
        end
        load_all();
        do_run(0, 0);
        for (int cyc = 1; cyc < 20; cyc++) begin
            checks++;
            if (obs_done[cyc] !== (cyc == 13)) begin
                errors++; $display("FAIL identity_done cycle %0d got %b required %b", cyc, obs_done[cyc], cyc == 13);
            end
            checks++;
            if (obs_busy[cyc] !== (cyc <= 13) || obs_clr[cyc] !== (cyc != 1)) begin
                errors++;
                $display("FAIL identity_busy_clr cycle %0d busy=%b clr_n=%b required %b %b",
                         cyc, obs_busy[cyc], obs_clr[cyc], cyc <= 13, cyc != 1);
            end
        end
        bad = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            for (int l = 0; l < 4; l++) begin
                if (lane(obs_a[cyc], l) != exp_a(l, cyc-2) || lane(obs_b[cyc], l) != exp_b(l, cyc-2)) begin
                    bad++;
                    $display("FAIL identity_feed cycle %0d lane %0d a=%0d b=%0d required %0d %0d", cyc, l,
                             lane(obs_a[cyc], l), lane(obs_b[cyc], l), exp_a(l, cyc-2), exp_b(l, cyc-2));
                end
            end
        end
        checks++;
        if (bad != 0) errors++;
        for (int k = 0; k < 16; k++) begin
            rd_row = 2'(k/4); rd_col = 2'(k%4); #1;
            checks++;
            if (int'($signed(rd_data)) != k + 1) begin
                errors++; $display("FAIL identity_result C[%0d][%0d] got %0d required %0d", k/4, k%4, $signed(rd_data), k + 1);
            end
        end
        $display("identity: done at cycle 13, results compared");
    endtask

    task automatic test_skew();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 0; mb[r][c] = 0;
            end
        end
        ma[0][0] = 3; ma[0][1] = 2; ma[0][2] = 1; ma[0][3] = 5;
        mb[0][0] = 12; mb[1][0] = 8; mb[2][0] = 4; mb[3][0] = 6;
        load_all();
        do_run(0, 0);
        checks++;
        if (lane(obs_a[2], 0) != 3 || lane(obs_b[2], 0) != 12) begin
            errors++; $display("FAIL skew_t0 a=%0d b=%0d required 3 12", lane(obs_a[2], 0), lane(obs_b[2], 0));
        end
        checks++;
        if (lane(obs_a[5], 0) != 5 || lane(obs_b[5], 0) != 6) begin
            errors++; $display("FAIL skew_t3 a=%0d b=%0d required 5 6", lane(obs_a[5], 0), lane(obs_b[5], 0));
        end
        rd_row = 0; rd_col = 0; #1;
        checks++;
        if (int'($signed(rd_data)) != 86) begin
            errors++; $display("FAIL skew_c00 got %0d required 86", $signed(rd_data));
        end
        $display("skew: C[0][0]=%0d", $signed(rd_data));
    endtask

    task automatic test_signed_extreme();
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    ma[r][c] = -128; mb[r][c] = (pass == 0) ? -128 : 127;
                end
            end
            load_all();
            do_run(0, 0);
            for (int k = 0; k < 16; k++) begin
                rd_row = 2'(k/4); rd_col = 2'(k%4); #1;
                checks++;
                if (int'($signed(rd_data)) != ((pass == 0) ? 65536 : -65024)) begin
                    errors++; $display("FAIL signed_extreme pass %0d C[%0d] got %0d required %0d",
                                       pass, k, $signed(rd_data), (pass == 0) ? 65536 : -65024);
                end
            end
            $display("signed_extreme: pass %0d compared", pass);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            randomize_mats();
            load_all();
            do_run(0, 0);
            for (int k = 0; k < 16; k++) begin
                rd_row = 2'(k/4); rd_col = 2'(k%4); #1;
                checks++;
                if (int'($signed(rd_data)) != ref_c(k/4, k%4)) begin
                    errors++; $display("FAIL random it %0d C[%0d][%0d] got %0d required %0d",
                                       it, k/4, k%4, $signed(rd_data), ref_c(k/4, k%4));
                end
            end
            $display("random: iteration %0d compared", it);
        end
    endtask

    task automatic test_ignored_inputs();
        int dcount;
        randomize_mats();
        load_all();
        for (int run = 0; run < 2; run++) begin
            do_run(run == 0, 0);
            dcount = 0;
            for (int cyc = 1; cyc < 20; cyc++) if (obs_done[cyc] === 1'b1) dcount++;
            checks++;
            if (dcount != 1 || obs_rdy[4] !== 0 || obs_busy[16] !== 0) begin
                errors++; $display("FAIL ignored run %0d done_pulses=%0d ready_in_feed=%b busy_after=%b required 1 0 0",
                                   run, dcount, obs_rdy[4], obs_busy[16]);
            end
            for (int k = 0; k < 16; k++) begin
                rd_row = 2'(k/4); rd_col = 2'(k%4); #1;
                checks++;
                if (int'($signed(rd_data)) != ref_c(k/4, k%4)) begin
                    errors++; $display("FAIL ignored_result run %0d C[%0d] got %0d required %0d",
                                       run, k, $signed(rd_data), ref_c(k/4, k%4));
                end
            end
            $display("ignored_inputs: run %0d compared", run);
        end
    endtask

    task automatic test_same_cycle_write();
        randomize_mats();
        load_all();
        do_run(0, 1);
        checks++;
        if (lane(obs_a[2], 0) != 9) begin
            errors++; $display("FAIL same_cycle a lane0 at t0 got %0d required 9", lane(obs_a[2], 0));
        end
        rd_row = 0; rd_col = 1; #1;
        checks++;
        if (int'($signed(rd_data)) != ref_c(0, 1)) begin
            errors++; $display("FAIL same_cycle C[0][1] got %0d required %0d", $signed(rd_data), ref_c(0, 1));
        end
        $display("same_cycle_write: a lane0 t0=%0d", lane(obs_a[2], 0));
    endtask

    task automatic test_mid_reset();
        int dcount;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        rst = 1;
        rd_row = 0; rd_col = 1; #1;
        checks++;
        if (busy !== 0 || arr_clr_n !== 0 || rd_data !== '0 || done !== 0) begin
            errors++; $display("FAIL mid_reset busy=%b clr_n=%b rd=%0d done=%b required 0 0 0 0",
                               busy, arr_clr_n, rd_data, done);
        end
        dcount = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        rst = 0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin ma[r][c] = 0; mb[r][c] = 0; end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        checks++;
        if (dcount != 0 || ld_ready !== 1 || busy !== 0) begin
            errors++; $display("FAIL mid_reset_after done_pulses=%0d ready=%b busy=%b required 0 1 0", dcount, ld_ready, busy);
        end
        do_run(0, 0);
        for (int k = 0; k < 16; k++) begin
            rd_row = 2'(k/4); rd_col = 2'(k%4); #1;
            checks++;
            if (rd_data !== '0) begin
                errors++; $display("FAIL mid_reset_buffers C[%0d] got %0d required 0", k, $signed(rd_data));
            end
        end
        $display("mid_reset: checked");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_skew();
        test_signed_extreme();
        test_random();
        test_ignored_inputs();
        test_same_cycle_write();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
